seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Upstream feeder for the per-digit seven-segment decoder on the Nexys-class 4-digit display.
- Takes a binary game value (score/timer) and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) FSM.
- Time-multiplexes the digits: drives one 4-bit digit code to the decoder plus active-low anode enables, one digit per refresh period.
- Display registers update atomically, so a digit never shows a half-converted value.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range ≥2.
- VAL_W, 14, width of the binary input value; fixed so that 9999 is representable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value  in  VAL_W  binary value to display.
- value_valid  in  1  single-cycle request to convert and display value.
- digit  out  4  BCD code for the active digit; 4'hF means blank.
- an  out  4  anode enables, active-low, one-hot-low; bit0 is the rightmost digit.
- busy  out  1  high while a conversion is in flight.
- sat  out  1  sticky-until-next-conversion flag; set when value exceeded 9999.

Behaviour:
- Reset (async assert, sync release):
  - an=4'b1111, digit=4'h0, busy=0, sat=0.
  - Display registers = 0; scan index = 0; refresh counter = 0; FSM in IDLE.
- Conversion FSM states are IDLE, SHIFT and COMMIT.
- IDLE:
  - When value_valid=1, capture min(value, 9999) and set sat_next = (value > 9999).
  - Clear the 16-bit BCD accumulator and go to SHIFT with bit counter = 0.
- SHIFT: exactly VAL_W cycles.
  - Each cycle, first add 3 to any BCD nibble ≥5.
  - Then left-shift {bcd, bin} by 1.
  - On the last count, go to COMMIT.
- COMMIT: one cycle.
  - Load the display registers and sat from the accumulator.
  - Go to IDLE.
- Latency and busy:
  - value_valid at cycle T makes busy high in T+1..T+VAL_W+1.
  - New digits are visible on digit from T+VAL_W+2.
- value_valid while busy:
  - Latch a single pending request, storing the latest value.
  - The pending request starts in the cycle after COMMIT.
  - Further requests overwrite the pending value; there is no queue deeper than 1.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index advances 0→1→2→3→0.
  - an and digit are registered together; they change in the same cycle.
- First slot after reset: an stays 4'b1111 until the first wrap (REFRESH_DIV cycles), then becomes 4'b1110 with digit = ones.
- Slot mapping: index0=ones→an 1110, index1=tens→1101, index2=hundreds→1011, index3=thousands→0111.
- Display changes mid-slot: the new digit appears immediately on the current anode. No anode blanking is required.
- Reset asserted mid-conversion: the conversion is aborted and the pending request is dropped.

Optional Feature:
- LEADING_ZERO_BLANK_EN
- Defined:
  - Any leading zero digit drives 4'hF in its slot; the decoder renders 4'hF blank.
  - The ones digit is never blanked, so 0 shows as "   0".
  - The anode still asserts in blanked slots.
- Undefined: all four digits are always shown, e.g. 42 shows as "0042".

Decomposition:
- Shared package seg7_pkg holds:
  - localparams SEG_DIGITS=4, BCD_MAX=9999, DIGIT_BLANK=4'hF;
  - the anode one-hot-low constants per index;
  - the FSM state encoding.
- One sub-module, bin2bcd_seq, holds the IDLE/SHIFT/COMMIT FSM, accumulator and pending latch.
- The top holds the refresh counter, scan index and output muxing.

Test Plan:
- Use REFRESH_DIV=4 for all scenarios.
- Reset, then idle 20 cycles:
  - an=1111 for 4 cycles, then 1110,1101,1011,0111 repeating every 4 cycles;
  - digit=0 in every slot.
- value=1234 with value_valid pulsed at T:
  - busy high T+1..T+15;
  - from T+16, slots show digit 4,3,2,1 on an 1110,1101,1011,0111.
- value=12000 pulsed:
  - display 9,9,9,9 and sat=1;
  - a next pulse with value=5 clears sat and shows 5,0,0,0.
- value_valid pulsed with 100, then again 3 cycles later with 7, then again with 8 while busy:
  - 100 commits first;
  - then 8 is converted; 7 is never displayed.
- rst_n dropped at SHIFT cycle 6 of value=4321:
  - outputs return to reset values asynchronously;
  - after release, the display shows 0 and busy=0.
- With LEADING_ZERO_BLANK_EN, value=42:
  - slots show 2,4,F,F;
  - value=0 shows 0,F,F,F.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and FSM encoding for the seven-segment scan driver.
package seg7_pkg;

   localparam int unsigned SEG_DIGITS  = 4;
   localparam int unsigned BCD_MAX     = 9999;
   localparam logic [3:0]  DIGIT_BLANK = 4'hF;

   localparam logic [3:0] AN_NONE  = 4'b1111;
   localparam logic [3:0] AN_ONES  = 4'b1110;
   localparam logic [3:0] AN_TENS  = 4'b1101;
   localparam logic [3:0] AN_HUNDS = 4'b1011;
   localparam logic [3:0] AN_THOUS = 4'b0111;

   typedef enum logic [1:0] {
      CONV_IDLE,
      CONV_SHIFT,
      CONV_COMMIT
   } conv_state_e;

   function automatic logic [3:0] an_for_index(input logic [1:0] idx);
      logic [3:0] an;
      case (idx)
         2'd0:    an = AN_ONES;
         2'd1:    an = AN_TENS;
         2'd2:    an = AN_HUNDS;
         default: an = AN_THOUS;
      endcase
      return an;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with a one-deep pending request latch.
// Display registers and sat are loaded atomically in COMMIT.
module bin2bcd_seq
   import seg7_pkg::*;
#(
   parameter int unsigned VAL_W = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [VAL_W-1:0] value,
   input  logic             value_valid,
   output logic             busy,
   output logic             sat,
   output logic [15:0]      disp_next
);

   localparam int unsigned    CNT_W = $clog2(VAL_W);
   localparam logic [VAL_W-1:0] MAX_V = VAL_W'(BCD_MAX);

   conv_state_e      state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [VAL_W-1:0] bin_q, bin_d;
   logic [15:0]      bcd_q, bcd_d;
   logic             sat_acc_q, sat_acc_d;
   logic [15:0]      disp_q, disp_d;
   logic             sat_q, sat_d;
   logic             pend_q, pend_d;
   logic [VAL_W-1:0] pend_val_q, pend_val_d;

   logic [15:0]      adj;
   logic             req;
   logic [VAL_W-1:0] req_val;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      sat_acc_d  = sat_acc_q;
      disp_d     = disp_q;
      sat_d      = sat_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;

      adj = bcd_q;
      for (int unsigned i = 0; i < SEG_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end

      // A fresh request in IDLE outranks the latched one: it is the latest value.
      req     = value_valid | pend_q;
      req_val = value_valid ? value : pend_val_q;

      case (state_q)
         CONV_IDLE: begin
            if (req) begin
               bin_d     = (req_val > MAX_V) ? MAX_V : req_val;
               sat_acc_d = (req_val > MAX_V);
               bcd_d     = '0;
               bit_cnt_d = '0;
               pend_d    = 1'b0;
               state_d   = CONV_SHIFT;
            end
         end
         CONV_SHIFT: begin
            {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
            bit_cnt_d      = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(VAL_W - 1)) state_d = CONV_COMMIT;
         end
         CONV_COMMIT: begin
            disp_d  = bcd_q;
            sat_d   = sat_acc_q;
            state_d = CONV_IDLE;
         end
         default: state_d = CONV_IDLE;
      endcase

      if (value_valid && (state_q != CONV_IDLE)) begin
         pend_d     = 1'b1;
         pend_val_d = value;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CONV_IDLE;
         bit_cnt_q  <= '0;
         bin_q      <= '0;
         bcd_q      <= '0;
         sat_acc_q  <= 1'b0;
         disp_q     <= '0;
         sat_q      <= 1'b0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         sat_acc_q  <= sat_acc_d;
         disp_q     <= disp_d;
         sat_q      <= sat_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
      end
   end

   assign busy      = (state_q != CONV_IDLE);
   assign sat       = sat_q;
   assign disp_next = disp_d;

endmodule

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD feeder and 4-digit anode scanner for a seven-segment decoder.
// Optional macro LEADING_ZERO_BLANK_EN drives DIGIT_BLANK for leading zeros.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned VAL_W       = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [VAL_W-1:0] value,
   input  logic             value_valid,
   output logic [3:0]       digit,
   output logic [3:0]       an,
   output logic             busy,
   output logic             sat
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic             started_q, started_d;
   logic [3:0]       an_q, an_d;
   logic [3:0]       digit_q, digit_d;
   logic [15:0]      disp_next;
   logic [15:0]      shown;

   bin2bcd_seq #(.VAL_W(VAL_W)) u_conv (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .value_valid (value_valid),
      .busy        (busy),
      .sat         (sat),
      .disp_next   (disp_next)
   );

   // The first wrap only enables the anodes; index 0 is shown before advancing.
   always_comb begin
      cnt_d     = cnt_q + 1'b1;
      idx_d     = idx_q;
      started_d = started_q;
      if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
         cnt_d     = '0;
         started_d = 1'b1;
         if (started_q) idx_d = idx_q + 1'b1;
      end

      shown = disp_next;
`ifdef LEADING_ZERO_BLANK_EN
      if (disp_next[15:12] == 4'd0) shown[15:12] = DIGIT_BLANK;
      if (disp_next[15:8] == 8'd0)  shown[11:8]  = DIGIT_BLANK;
      if (disp_next[15:4] == 12'd0) shown[7:4]   = DIGIT_BLANK;
`endif

      digit_d = shown[{idx_d, 2'b00} +: 4];
      an_d    = started_d ? an_for_index(idx_d) : AN_NONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         started_q <= 1'b0;
         an_q      <= AN_NONE;
         digit_q   <= '0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         started_q <= started_d;
         an_q      <= an_d;
         digit_q   <= digit_d;
      end
   end

   assign an    = an_q;
   assign digit = digit_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with REFRESH_DIV=4.
// Honours LEADING_ZERO_BLANK_EN in its expected display model.
module tb_seg7_scan_driver;

   typedef struct {
      logic [15:0] disp;
      logic        sat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [13:0] value;
   logic        value_valid;
   logic [3:0]  digit;
   logic [3:0]  an;
   logic        busy;
   logic        sat;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   exp_t        sb[$];
   logic [15:0] cur_disp;
   logic        busy_prev;
   int          s;

   seg7_scan_driver #(.REFRESH_DIV(4), .VAL_W(14)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .value_valid (value_valid),
      .digit       (digit),
      .an          (an),
      .busy        (busy),
      .sat         (sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic logic [15:0] exp_disp(input int v);
      int d;
      logic [15:0] r;
      d = (v > 9999) ? 9999 : v;
      r = {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
`ifdef LEADING_ZERO_BLANK_EN
      if (d < 1000) r[15:12] = 4'hF;
      if (d < 100)  r[11:8]  = 4'hF;
      if (d < 10)   r[7:4]   = 4'hF;
`endif
      return r;
   endfunction

   // Monitor: counts cycles since reset release, checks scan order and digits,
   // and pops the scoreboard whenever a conversion finishes.
   always @(negedge clk) begin
      logic [3:0] exp_an;
      int         slot;
      exp_t       e;
      if (!rst_n) begin
         s         = 0;
         busy_prev = 1'b0;
         cur_disp  = exp_disp(0);
         sb.delete();
      end else begin
         s++;
         if (busy_prev && !busy) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e        = sb.pop_front();
               cur_disp = e.disp;
               check("sat", 32'(sat), 32'(e.sat));
            end
         end
         busy_prev = busy;
         slot      = ((s - 4) / 4) % 4;
         exp_an    = (s < 4) ? 4'b1111 : ~(4'b0001 << slot);
         check("an", 32'(an), 32'(exp_an));
         if (s >= 4) check("digit", 32'(digit), 32'(cur_disp[4*slot +: 4]));
      end
   end

   task automatic pulse(input int v, input bit expect_it);
      exp_t e;
      @(negedge clk);
      value       = 14'(v);
      value_valid = 1'b1;
      if (expect_it) begin
         e.disp = exp_disp(v);
         e.sat  = (v > 9999);
         sb.push_back(e);
      end
      @(negedge clk);
      value_valid = 1'b0;
   endtask

   task automatic convert_and_wait(input int v);
      pulse(v, 1'b1);
      repeat (36) @(negedge clk);
   endtask

   initial begin
      rst_n       = 1'b0;
      value       = '0;
      value_valid = 1'b0;
      #12;
      check("rst_an", 32'(an), 32'hF);
      check("rst_digit", 32'(digit), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_sat", 32'(sat), 32'h0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // 1234: busy exactly T+1..T+15
      pulse(1234, 1'b1);
      check("busy_t1", 32'(busy), 32'h1);
      for (int k = 2; k <= 15; k++) begin
         @(negedge clk);
         check("busy_run", 32'(busy), 32'h1);
      end
      @(negedge clk);
      check("busy_t16", 32'(busy), 32'h0);
      repeat (20) @(negedge clk);

      convert_and_wait(12000);
      convert_and_wait(5);
      convert_and_wait(9999);
      convert_and_wait(42);
      convert_and_wait(0);

      // pending latch: 100 commits, 7 is overwritten by 8
      pulse(100, 1'b1);
      @(negedge clk);
      pulse(7, 1'b0);
      repeat (2) @(negedge clk);
      pulse(8, 1'b1);
      repeat (50) @(negedge clk);

      convert_and_wait(10000);
      check("sat_before_rst", 32'(sat), 32'h1);

      // async reset during SHIFT cycle 6 of 4321
      pulse(4321, 1'b1);
      repeat (6) @(negedge clk);
      check("an_scanning", 32'(an != 4'hF), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_an", 32'(an), 32'hF);
      check("arst_digit", 32'(digit), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      check("arst_sat", 32'(sat), 32'h0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'h0);
      check("post_rst_sat", 32'(sat), 32'h0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
